dpram_rd_stream: RTL and testbench

DPRAM_RD_STREAM -- requirements
Module: dpram_rd_stream

---
 rtl/dpram_rd_stream.sv | 118 +++++++++++
 tb/tb_dpram_rd_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dpram_rd_stream.sv
// Streams cmd_len words from a dual-port RAM read port onto an AXI-Stream master,
// with credit-limited read issue into a small skid FIFO. Define DPRAM_RD_STREAM_TLAST_EN to add m_axis_tlast.
module dpram_rd_stream #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 16,
    parameter int RD_LATENCY = 3,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_ren,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
`ifdef DPRAM_RD_STREAM_TLAST_EN
    output logic                  m_axis_tlast,
`endif
    output logic                  busy
);

    // state | meaning
    // IDLE  | cmd_ready high, waiting for a non-empty command
    // READ  | issuing RAM reads as FIFO credit allows
    // DRAIN | all reads issued, waiting for the last word to leave the stream
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    // The final latency cycle is the FIFO write itself, so the tracking pipe is one shorter.
    localparam int PIPE = RD_LATENCY - 1;
    localparam int CW   = $clog2(SKID_DEPTH + 1) + 1;
    localparam int PW   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  rem_len;
    logic [PIPE-1:0]       vld_sr;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         fifo_cnt;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [SKID_DEPTH];
    logic                  accept, push, pop, room;

    assign accept        = cmd_valid & cmd_ready;
    assign push          = vld_sr[PIPE-1];
    assign m_axis_tvalid = (fifo_cnt != '0);
    assign m_axis_tdata  = fifo_mem[rd_ptr];
    assign pop           = m_axis_tvalid & m_axis_tready;
    // A word popped this cycle frees its slot in time for a read issued now.
    assign room          = (in_flight + fifo_cnt + CW'(1)) <= (CW'(SKID_DEPTH) + CW'(pop));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && cmd_len != '0) state_nxt = READ;
            READ:    if (ram_ren && rem_len == LEN_WIDTH'(1)) state_nxt = DRAIN;
            DRAIN:   if (pop && fifo_cnt == CW'(1) && in_flight == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        ram_ren   = (state == READ) && room && !rst;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_raddr <= '0;
            rem_len   <= '0;
            vld_sr    <= '0;
            in_flight <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (accept) begin
                ram_raddr <= cmd_addr;
                rem_len   <= cmd_len;
            end else if (ram_ren) begin
                ram_raddr <= ram_raddr + ADDR_WIDTH'(1);
                rem_len   <= rem_len - LEN_WIDTH'(1);
            end
            vld_sr    <= (vld_sr << 1) | PIPE'(ram_ren);
            in_flight <= in_flight + CW'(ram_ren) - CW'(push);
            fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) wr_ptr <= (wr_ptr == PW'(SKID_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(SKID_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_dout;
    end

`ifdef DPRAM_RD_STREAM_TLAST_EN
    logic [LEN_WIDTH-1:0] out_rem;

    always_ff @(posedge clk) begin
        if (rst)         out_rem <= '0;
        else if (accept) out_rem <= cmd_len;
        else if (pop)    out_rem <= out_rem - LEN_WIDTH'(1);
    end

    assign m_axis_tlast = m_axis_tvalid && (out_rem == LEN_WIDTH'(1));
`endif

endmodule

// File: tb/tb_dpram_rd_stream.sv
// Randomized bench for dpram_rd_stream: a pipelined RAM model plus a queue-based
// reference of the expected read addresses and stream words.
module tb_dpram_rd_stream;

    localparam int AW   = 16;
    localparam int DW   = 128;
    localparam int LW   = 16;
    localparam int RDL  = 3;
    localparam int SKID = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] ram_raddr;
    logic          ram_ren;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          busy;
`ifdef DPRAM_RD_STREAM_TLAST_EN
    logic          m_axis_tlast;
`endif

    dpram_rd_stream #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .RD_LATENCY(RDL), .SKID_DEPTH(SKID)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_dout(ram_dout),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
`ifdef DPRAM_RD_STREAM_TLAST_EN
        .m_axis_tlast(m_axis_tlast),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [15:0] m7, m13;
        m7  = a * 16'd7;
        m13 = a * 16'd13;
        return {a ^ 16'hA5A5, m7, ~a, a, 16'hC3C3 ^ a, a + 16'h1111, m13, a};
    endfunction

    // RAM with its enable tied high: data for the address sampled at one edge
    // appears RDL-1 edges later.
    logic [AW-1:0] rpipe [RDL-1];
    always @(posedge clk) begin
        rpipe[0] <= ram_raddr;
        for (int i = 1; i < RDL - 1; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_dout = word_of(rpipe[RDL-2]);

    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] exp_q  [$];
    int n_iss = 0, n_del = 0;
    int cyc = 0, first_ren = -1, last_ren = -1, first_tv = -1, ren_cnt = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    bit stall_armed = 0;
    int stall_left  = 0;
    bit rnd_mode    = 0;

    always @(posedge clk) begin
        #1;
        if (stall_armed && m_axis_tvalid) begin
            stall_left  = 10;
            stall_armed = 0;
        end
        if (stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
        end else if (rnd_mode) m_axis_tready = ($urandom_range(0, 3) != 0);
        else                   m_axis_tready = 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("hold_valid", DW'(m_axis_tvalid), DW'(1));
                chk("hold_data", m_axis_tdata, prev_data);
            end
            if (ram_ren) begin
                ren_cnt++;
                n_iss++;
                if (first_ren < 0) first_ren = cyc;
                last_ren = cyc;
                if (addr_q.size() == 0) chk("extra_ren", DW'(ram_ren), DW'(0));
                else                    chk("raddr", DW'(ram_raddr), DW'(addr_q.pop_front()));
            end
            if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                n_del++;
                if (exp_q.size() == 0) chk("extra_word", DW'(m_axis_tvalid), DW'(0));
                else begin
`ifdef DPRAM_RD_STREAM_TLAST_EN
                    chk("tlast", DW'(m_axis_tlast), DW'(exp_q.size() == 1));
`endif
                    chk("tdata", m_axis_tdata, exp_q.pop_front());
                end
            end
            if (ram_ren) chk("outstanding", DW'((n_iss - n_del) <= SKID), DW'(1));
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    task automatic run_cmd(input logic [AW-1:0] a, input int len);
        int k;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = LW'(len);
        chk("cmd_ready", DW'(cmd_ready), DW'(1));
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(a + AW'(i));
            exp_q.push_back(word_of(a + AW'(i)));
        end
        first_ren = -1; last_ren = -1; first_tv = -1; ren_cnt = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (len > 0) begin
            chk("busy_on_accept", DW'(busy), DW'(1));
            k = 0;
            while (busy && k < 3000) begin
                @(negedge clk);
                k++;
            end
            chk("done_in_time", DW'(busy), DW'(0));
        end
        chk("all_delivered", DW'(exp_q.size()), DW'(0));
        chk("ren_count", DW'(ren_cnt), DW'(len));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outs", DW'({cmd_ready, ram_ren, m_axis_tvalid, busy}), DW'(4'b1000));
        chk("rst_raddr", DW'(ram_raddr), DW'(0));
        rst = 1'b0;

        run_cmd(16'h0010, 4);
        chk("first_word_latency", DW'(first_tv - first_ren), DW'(RDL));
        chk("ren_back_to_back", DW'(last_ren - first_ren), DW'(3));

        run_cmd(16'hFFFE, 4);
        chk("wrap_back_to_back", DW'(last_ren - first_ren), DW'(3));

        stall_armed = 1;
        run_cmd(16'h0400, 16);

        run_cmd(16'h0033, 0);
        for (int i = 0; i < 8; i++) begin
            chk("len0_quiet", DW'({cmd_ready, ram_ren, m_axis_tvalid, busy}), DW'(4'b1000));
            @(negedge clk);
        end

        // Reset two cycles into an 8-word transfer.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 16'h0100; cmd_len = 16'd8;
        for (int i = 0; i < 8; i++) begin
            addr_q.push_back(16'h0100 + AW'(i));
            exp_q.push_back(word_of(16'h0100 + AW'(i)));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        addr_q.delete(); exp_q.delete(); n_iss = 0; n_del = 0;
        @(negedge clk);
        chk("midrst_outs", DW'({cmd_ready, ram_ren, m_axis_tvalid, busy}), DW'(4'b1000));
        chk("midrst_raddr", DW'(ram_raddr), DW'(0));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_stale", DW'(m_axis_tvalid), DW'(0));
        end
        run_cmd(16'h0200, 8);

        rnd_mode = 1;
        for (int i = 0; i < 25; i++)
            run_cmd(AW'($urandom), int'($urandom_range(0, 20)));
        rnd_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
